// File: rtl/dma_csr_multichan.sv
// ---------------------------------------------------------------------------
// dma_csr_multichan
//   Per-channel CSR slave for NUM_CH independent DMA read/write-master pairs.
//   Each channel holds read/write start addresses, a transfer length, IE, and
//   DONE/ERR flags. It also has a completed-transfer counter and a two-state
//   IDLE/RUN sequencer. The sequencer issues start/abort pulses and consumes
//   completion pulses. A single registered level interrupt is the OR of the
//   enabled channel flags.
//
// Ports
//   iClk, iReset_n      clock (rising edge), asynchronous active-low reset
//   iChipselect/iRead/iWrite/iAddress/iWritedata/oReaddata
//                       Avalon-MM style CSR port; iAddress = {channel, word}
//   oRM_startaddress    per-channel read start address, ch n at [32n+:32]
//   oWM_startaddress    per-channel write start address, ch n at [32n+:32]
//   oLength             per-channel length, ch n at [LEN_W*n+:LEN_W]
//   oStart, oAbort      one-cycle pulses per channel
//   iWM_done            one-cycle completion pulse per channel
//   oIrq                level interrupt
// ---------------------------------------------------------------------------
module dma_csr_multichan #(
    parameter  int NUM_CH = 4,
    parameter  int LEN_W  = 32,
    localparam int CH_AW  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                      iClk,
    input  logic                      iReset_n,
    input  logic                      iChipselect,
    input  logic                      iRead,
    input  logic                      iWrite,
    input  logic [CH_AW+2:0]          iAddress,
    input  logic [31:0]               iWritedata,
    output logic [31:0]               oReaddata,
    output logic [NUM_CH*32-1:0]      oRM_startaddress,
    output logic [NUM_CH*32-1:0]      oWM_startaddress,
    output logic [NUM_CH*LEN_W-1:0]   oLength,
    output logic [NUM_CH-1:0]         oStart,
    output logic [NUM_CH-1:0]         oAbort,
    input  logic [NUM_CH-1:0]         iWM_done,
    output logic                      oIrq
);

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_e;

    state_e                        state_q [NUM_CH];
    state_e                        state_d [NUM_CH];
    logic [NUM_CH-1:0][31:0]       raddr_q, raddr_d;
    logic [NUM_CH-1:0][31:0]       waddr_q, waddr_d;
    logic [NUM_CH-1:0][LEN_W-1:0]  len_q, len_d;
    logic [NUM_CH-1:0][31:0]       dcnt_q, dcnt_d;
    logic [NUM_CH-1:0]             ie_q, ie_d;
    logic [NUM_CH-1:0]             done_q, done_d;
    logic [NUM_CH-1:0]             err_q, err_d;
    logic [NUM_CH-1:0]             start_q, start_d;
    logic [NUM_CH-1:0]             abort_q, abort_d;
    logic                          irq_q, irq_d;
    logic [31:0]                   rdata_q, rdata_d;

    logic [CH_AW-1:0]  ch_sel;
    logic [2:0]        word;
    logic              ch_ok;
    logic              wr_en, rd_en;
    logic [NUM_CH-1:0] wr_hit;   // this channel is the write target
    logic [NUM_CH-1:0] go_ev;    // GO without ABORT in the same write
    logic [NUM_CH-1:0] ab_ev;    // ABORT bit written
    logic [NUM_CH-1:0] len_nz;

    assign ch_sel = iAddress[CH_AW+2:3];
    assign word   = iAddress[2:0];
    assign ch_ok  = (32'(ch_sel) < NUM_CH);
    assign wr_en  = iChipselect & iWrite;
    assign rd_en  = iChipselect & iRead;

    always_comb begin
        wr_hit = '0;
        go_ev  = '0;
        ab_ev  = '0;
        len_nz = '0;
        for (int n = 0; n < NUM_CH; n++) begin
            wr_hit[n] = wr_en && ch_ok && (ch_sel == CH_AW'(n));
            ab_ev[n]  = wr_hit[n] && (word == 3'd4) && iWritedata[2];
            go_ev[n]  = wr_hit[n] && (word == 3'd4) && iWritedata[0] && !iWritedata[2];
            len_nz[n] = (len_q[n] != '0);
        end
    end

    // Sequencer state register
    always_ff @(posedge iClk or negedge iReset_n) begin
        if (!iReset_n) begin
            for (int n = 0; n < NUM_CH; n++) state_q[n] <= IDLE;
        end else begin
            for (int n = 0; n < NUM_CH; n++) state_q[n] <= state_d[n];
        end
    end

    // Sequencer next state; completion outranks a same-cycle ABORT
    always_comb begin
        for (int n = 0; n < NUM_CH; n++) begin
            state_d[n] = state_q[n];
            case (state_q[n])
                IDLE: if (go_ev[n] && len_nz[n]) state_d[n] = RUN;
                RUN:  if (iWM_done[n] || ab_ev[n]) state_d[n] = IDLE;
                default: state_d[n] = IDLE;
            endcase
        end
    end

    // Sequencer outputs plus CSR register updates
    always_comb begin
        raddr_d = raddr_q;
        waddr_d = waddr_q;
        len_d   = len_q;
        dcnt_d  = dcnt_q;
        ie_d    = ie_q;
        done_d  = done_q;
        err_d   = err_q;
        start_d = '0;
        abort_d = '0;
        for (int n = 0; n < NUM_CH; n++) begin
            // Configuration is frozen while the channel runs; IE and W1C are not
            if (wr_hit[n] && state_q[n] == IDLE) begin
                case (word)
                    3'd0:    raddr_d[n] = iWritedata;
                    3'd1:    waddr_d[n] = iWritedata;
                    3'd2:    len_d[n]   = iWritedata[LEN_W-1:0];
                    default: ;
                endcase
            end
            if (wr_hit[n] && word == 3'd4) ie_d[n] = iWritedata[1];
            // W1C first, so flag sets below take priority
            if (wr_hit[n] && word == 3'd5) begin
                if (iWritedata[0]) done_d[n] = 1'b0;
                if (iWritedata[2]) err_d[n]  = 1'b0;
            end
            case (state_q[n])
                IDLE: begin
                    if (go_ev[n]) begin
                        if (len_nz[n]) begin
                            start_d[n] = 1'b1;
                            done_d[n]  = 1'b0;
                            err_d[n]   = 1'b0;
                        end else begin
                            // Zero-length transfer completes immediately
                            done_d[n]  = 1'b1;
                            dcnt_d[n]  = dcnt_q[n] + 32'd1;
                        end
                    end
                end
                RUN: begin
                    if (iWM_done[n]) begin
                        done_d[n] = 1'b1;
                        dcnt_d[n] = dcnt_q[n] + 32'd1;
                    end else if (ab_ev[n]) begin
                        err_d[n]   = 1'b1;
                        abort_d[n] = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Interrupt follows the registered flags, so it lags them by one cycle
    assign irq_d = |((done_q | err_q) & ie_q);

    // Read mux; data held between reads
    always_comb begin
        rdata_d = rdata_q;
        if (rd_en) begin
            rdata_d = '0;
            for (int n = 0; n < NUM_CH; n++) begin
                if (ch_ok && ch_sel == CH_AW'(n)) begin
                    case (word)
                        3'd0:    rdata_d = raddr_q[n];
                        3'd1:    rdata_d = waddr_q[n];
                        3'd2:    rdata_d = 32'(len_q[n]);
                        3'd4:    rdata_d = {30'd0, ie_q[n], 1'b0};
                        3'd5:    rdata_d = {29'd0, err_q[n], (state_q[n] == RUN), done_q[n]};
                        3'd6:    rdata_d = dcnt_q[n];
                        default: rdata_d = '0;
                    endcase
                end
            end
        end
    end

    always_ff @(posedge iClk or negedge iReset_n) begin
        if (!iReset_n) begin
            raddr_q <= '0;
            waddr_q <= '0;
            len_q   <= '0;
            dcnt_q  <= '0;
            ie_q    <= '0;
            done_q  <= '0;
            err_q   <= '0;
            start_q <= '0;
            abort_q <= '0;
            irq_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            raddr_q <= raddr_d;
            waddr_q <= waddr_d;
            len_q   <= len_d;
            dcnt_q  <= dcnt_d;
            ie_q    <= ie_d;
            done_q  <= done_d;
            err_q   <= err_d;
            start_q <= start_d;
            abort_q <= abort_d;
            irq_q   <= irq_d;
            rdata_q <= rdata_d;
        end
    end

    assign oReaddata        = rdata_q;
    assign oRM_startaddress = raddr_q;
    assign oWM_startaddress = waddr_q;
    assign oLength          = len_q;
    assign oStart           = start_q;
    assign oAbort           = abort_q;
    assign oIrq             = irq_q;

endmodule

// File: tb/tb_dma_csr_multichan.sv
module tb_dma_csr_multichan;

    localparam int NUM_CH = 5;
    localparam int LEN_W  = 16;
    localparam int AW     = 6;

    logic                     iClk = 1'b0;
    logic                     iReset_n = 1'b0;
    logic                     iChipselect = 1'b0;
    logic                     iRead = 1'b0;
    logic                     iWrite = 1'b0;
    logic [AW-1:0]            iAddress = '0;
    logic [31:0]              iWritedata = '0;
    logic [31:0]              oReaddata;
    logic [NUM_CH*32-1:0]     oRM_startaddress;
    logic [NUM_CH*32-1:0]     oWM_startaddress;
    logic [NUM_CH*LEN_W-1:0]  oLength;
    logic [NUM_CH-1:0]        oStart;
    logic [NUM_CH-1:0]        oAbort;
    logic [NUM_CH-1:0]        iWM_done = '0;
    logic                     oIrq;

    dma_csr_multichan #(.NUM_CH(NUM_CH), .LEN_W(LEN_W)) dut (
        .iClk(iClk), .iReset_n(iReset_n), .iChipselect(iChipselect),
        .iRead(iRead), .iWrite(iWrite), .iAddress(iAddress),
        .iWritedata(iWritedata), .oReaddata(oReaddata),
        .oRM_startaddress(oRM_startaddress), .oWM_startaddress(oWM_startaddress),
        .oLength(oLength), .oStart(oStart), .oAbort(oAbort),
        .iWM_done(iWM_done), .oIrq(oIrq)
    );

    always #5 iClk = ~iClk;

    int total = 0;
    int bad   = 0;
    int start_cnt [NUM_CH];
    int abort_cnt [NUM_CH];

    initial begin
        for (int n = 0; n < NUM_CH; n++) begin
            start_cnt[n] = 0;
            abort_cnt[n] = 0;
        end
    end

    // Pulses are one cycle wide, so sampling on the falling edge counts each once
    always @(negedge iClk) begin
        for (int n = 0; n < NUM_CH; n++) begin
            if (oStart[n]) start_cnt[n]++;
            if (oAbort[n]) abort_cnt[n]++;
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
        end
    endtask

    function automatic logic [AW-1:0] adr(input int ch, input int w);
        logic [2:0] c3;
        logic [2:0] w3;
        c3 = 3'(ch);
        w3 = 3'(w);
        return {c3, w3};
    endfunction

    task automatic csr_write(input int ch, input int w, input logic [31:0] d);
        @(negedge iClk);
        iChipselect = 1'b1; iWrite = 1'b1; iAddress = adr(ch, w); iWritedata = d;
        @(posedge iClk); #1;
        iChipselect = 1'b0; iWrite = 1'b0;
    endtask

    task automatic csr_read(input int ch, input int w, output logic [31:0] d);
        @(negedge iClk);
        iChipselect = 1'b1; iRead = 1'b1; iAddress = adr(ch, w);
        @(posedge iClk); #1;
        d = oReaddata;
        iChipselect = 1'b0; iRead = 1'b0;
    endtask

    task automatic pulse_done(input int ch);
        @(negedge iClk);
        iWM_done[ch] = 1'b1;
        @(posedge iClk); #1;
        iWM_done[ch] = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge iClk);
        #1;
    endtask

    typedef struct {
        int          ch;
        int          word;
        logic [31:0] wdata;
        logic [31:0] exp;
        string       name;
    } vec_t;

    vec_t vecs [14];
    logic [31:0] rd;

    initial begin
        vecs[0]  = '{0, 0, 32'h0000_1000, 32'h0000_1000, "ch0_raddr"};
        vecs[1]  = '{0, 1, 32'h0000_2000, 32'h0000_2000, "ch0_waddr"};
        vecs[2]  = '{0, 2, 32'd64,        32'd64,        "ch0_len"};
        vecs[3]  = '{0, 3, 32'hFFFF_FFFF, 32'h0,         "ch0_rsvd3"};
        vecs[4]  = '{0, 7, 32'hFFFF_FFFF, 32'h0,         "ch0_rsvd7"};
        vecs[5]  = '{2, 2, 32'h0001_2345, 32'h0000_2345, "ch2_len_trunc"};
        vecs[6]  = '{2, 2, 32'd32,        32'd32,        "ch2_len"};
        vecs[7]  = '{1, 6, 32'd5,         32'h0,         "ch1_dcnt_ro"};
        vecs[8]  = '{1, 0, 32'hAAAA_5555, 32'hAAAA_5555, "ch1_raddr"};
        vecs[9]  = '{1, 2, 32'd16,        32'd16,        "ch1_len"};
        vecs[10] = '{4, 4, 32'h0000_0002, 32'h0000_0002, "ch4_ie_set"};
        vecs[11] = '{4, 4, 32'h0000_0000, 32'h0000_0000, "ch4_ie_clr"};
        vecs[12] = '{3, 5, 32'h0000_0007, 32'h0000_0000, "ch3_stat_idle"};
        vecs[13] = '{5, 0, 32'h0000_DEAD, 32'h0000_0000, "ch5_out_of_range"};

        // Reset state
        idle(3);
        check("rst_irq", 32'(oIrq), 32'h0);
        check("rst_start", 32'(oStart), 32'h0);
        check("rst_rdata", oReaddata, 32'h0);
        iReset_n = 1'b1;
        idle(2);
        csr_read(0, 5, rd); check("rst_stat0", rd, 32'h0);
        csr_read(2, 6, rd); check("rst_dcnt2", rd, 32'h0);

        // Register table: write then read back
        for (int i = 0; i < 14; i++) begin
            csr_write(vecs[i].ch, vecs[i].word, vecs[i].wdata);
            csr_read(vecs[i].ch, vecs[i].word, rd);
            check(vecs[i].name, rd, vecs[i].exp);
        end
        check("rm_addr0", oRM_startaddress[31:0], 32'h0000_1000);
        check("wm_addr0", oWM_startaddress[31:0], 32'h0000_2000);
        check("len_out2", 32'(oLength[2*LEN_W +: LEN_W]), 32'd32);

        // 1: ch0 transfer
        csr_write(0, 4, 32'h1);
        idle(2);
        check("t1_start_cnt", start_cnt[0], 1);
        csr_read(0, 5, rd); check("t1_busy", rd, 32'h2);
        pulse_done(0);
        csr_read(0, 5, rd); check("t1_stat_done", rd, 32'h1);
        csr_read(0, 6, rd); check("t1_dcnt", rd, 32'h1);

        // 2: ch2 interrupt
        csr_write(2, 4, 32'h3);
        idle(1);
        check("t2_start_cnt", start_cnt[2], 1);
        pulse_done(2);
        check("t2_irq_lag", 32'(oIrq), 32'h0);
        idle(1);
        check("t2_irq_set", 32'(oIrq), 32'h1);
        csr_write(2, 5, 32'h1);
        check("t2_irq_hold", 32'(oIrq), 32'h1);
        idle(1);
        check("t2_irq_clr", 32'(oIrq), 32'h0);

        // 3: ch1 busy freeze then abort
        csr_write(1, 4, 32'h1);
        csr_write(1, 2, 32'd8);
        csr_write(1, 0, 32'h1234_5678);
        csr_read(1, 2, rd); check("t3_len_frozen", rd, 32'd16);
        csr_read(1, 0, rd); check("t3_raddr_frozen", rd, 32'hAAAA_5555);
        csr_write(1, 4, 32'h1);
        csr_write(1, 4, 32'h4);
        idle(2);
        check("t3_abort_cnt", abort_cnt[1], 1);
        csr_read(1, 5, rd); check("t3_stat_err", rd, 32'h4);
        idle(3);
        check("t3_start_cnt", start_cnt[1], 1);

        // 4: zero length, out-of-range, GO+ABORT and stray done in IDLE
        csr_write(3, 4, 32'h1);
        idle(2);
        check("t4_no_start", start_cnt[3], 0);
        csr_read(3, 5, rd); check("t4_stat", rd, 32'h1);
        csr_read(3, 6, rd); check("t4_dcnt", rd, 32'h1);
        csr_read(5, 0, rd); check("t4_ch5_rd", rd, 32'h0);
        csr_write(4, 2, 32'd4);
        csr_write(4, 4, 32'h5);
        idle(2);
        check("t4_goab_start", start_cnt[4], 0);
        csr_read(4, 5, rd); check("t4_goab_stat", rd, 32'h0);
        pulse_done(4);
        csr_read(4, 5, rd); check("t4_idle_done_stat", rd, 32'h0);
        csr_read(4, 6, rd); check("t4_idle_done_dcnt", rd, 32'h0);

        // 5: same-cycle set vs W1C, done vs abort, counter wrap
        csr_write(0, 4, 32'h1);
        csr_read(0, 5, rd); check("t5_go_clears", rd, 32'h2);
        @(negedge iClk);
        iWM_done[0] = 1'b1;
        iChipselect = 1'b1; iWrite = 1'b1; iAddress = adr(0, 5); iWritedata = 32'h1;
        @(posedge iClk); #1;
        iWM_done[0] = 1'b0; iChipselect = 1'b0; iWrite = 1'b0;
        csr_read(0, 5, rd); check("t5_set_wins", rd, 32'h1);
        csr_write(0, 4, 32'h1);
        @(negedge iClk);
        iWM_done[0] = 1'b1;
        iChipselect = 1'b1; iWrite = 1'b1; iAddress = adr(0, 4); iWritedata = 32'h4;
        @(posedge iClk); #1;
        iWM_done[0] = 1'b0; iChipselect = 1'b0; iWrite = 1'b0;
        idle(2);
        check("t5_no_abort", abort_cnt[0], 0);
        csr_read(0, 5, rd); check("t5_done_wins", rd, 32'h1);
        csr_read(0, 6, rd); check("t5_dcnt3", rd, 32'd3);
        @(negedge iClk);
        force dut.dcnt_q = {32'd0, 32'd1, 32'd1, 32'd0, 32'hFFFF_FFFF};
        #1;
        release dut.dcnt_q;
        csr_read(0, 6, rd); check("t5_dcnt_preset", rd, 32'hFFFF_FFFF);
        csr_write(0, 4, 32'h1);
        pulse_done(0);
        csr_read(0, 6, rd); check("t5_dcnt_wrap", rd, 32'h0);

        // 6: asynchronous reset mid-transfer
        csr_write(0, 4, 32'h1);
        csr_read(0, 0, rd);
        check("t6_pre_rdata", rd, 32'h0000_1000);
        @(negedge iClk); #2;
        iReset_n = 1'b0;
        #1;
        check("t6_rdata", oReaddata, 32'h0);
        check("t6_rm_addr", oRM_startaddress[31:0], 32'h0);
        check("t6_len", 32'(oLength[LEN_W-1:0]), 32'h0);
        check("t6_irq", 32'(oIrq), 32'h0);
        idle(2);
        check("t6_no_abort", abort_cnt[0], 0);
        @(negedge iClk);
        iReset_n = 1'b1;
        csr_read(0, 5, rd); check("t6_stat", rd, 32'h0);
        csr_write(0, 2, 32'd12);
        csr_write(0, 4, 32'h1);
        idle(2);
        check("t6_restart", start_cnt[0], 6);
        csr_read(0, 5, rd); check("t6_busy", rd, 32'h2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
